// File: rtl/mult_pkg.sv
// mult_pkg: FSM state encoding and counter sizing shared by the mult_seq datapath.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned DEF_WIDTH = 32;

  // The counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  localparam int unsigned DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/fa_nbit.sv
// fa_nbit: N-bit ripple-carry adder, o_sum = i_a + i_b + i_cin, with carry-out.
module fa_nbit #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);

  logic w_carry;

  always_comb begin
    // NOTE: every combinational output gets a value before the loop so no path infers a latch.
    w_carry = i_cin;
    o_sum   = '0;
    for (int i = 0; i < N; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry;
      w_carry  = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_carry;
  end

endmodule

// File: rtl/mult_seq.sv
// mult_seq: shift-add sequential multiplier, WIDTH x WIDTH -> 2*WIDTH, fixed latency.
// Define MULT_SIGNED_EN for the sgn port and two's-complement mode (latency WIDTH+2, else WIDTH+1).
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULT_SIGNED_EN
  input  logic             sgn,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

`ifdef MULT_SIGNED_EN
  logic r_neg;

  // The most negative value negates to itself, which is its correct unsigned magnitude.
  assign w_a_mag = (sgn && a[WIDTH-1]) ? -a : a;
  assign w_b_mag = (sgn && b[WIDTH-1]) ? -b : b;
`else
  assign w_a_mag = a;
  assign w_b_mag = b;
`endif

  // The multiplier lives in r_acc_lo and shifts out LSB-first as product bits shift in.
  assign w_addend = r_acc_lo[0] ? r_mcand : '0;

  fa_nbit #(
    .N(WIDTH)
  ) u_add (
    .i_a   (r_acc_hi),
    .i_b   (w_addend),
    .i_cin (1'b0),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too, because reset must zero the visible product.
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef MULT_SIGNED_EN
      r_neg    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking updates so every register sees the pre-edge values of the others.
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= w_a_mag;
            r_acc_lo <= w_b_mag;
            r_acc_hi <= '0;
            r_cnt    <= CNT_W'(WIDTH);
            r_busy   <= 1'b1;
`ifdef MULT_SIGNED_EN
            r_neg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
            r_state  <= RUN;
          end
        end

        RUN: begin
          // Carry-out becomes the new MSB so no product bit is lost.
          {r_acc_hi, r_acc_lo} <= {w_cout, w_sum, r_acc_lo[WIDTH-1:1]};
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
`ifdef MULT_SIGNED_EN
            r_state <= FIX;
`else
            r_state <= DONE;
`endif
          end
        end

`ifdef MULT_SIGNED_EN
        FIX: begin
          if (r_neg) begin
            {r_acc_hi, r_acc_lo} <= -{r_acc_hi, r_acc_lo};
          end
          r_state <= DONE;
        end
`endif

        DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign prod_lo = r_acc_lo;
  assign prod_hi = r_acc_hi;

endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: scenario tasks with a scoreboard queue of expected products for mult_seq.
module tb_mult_seq;

  localparam int W = 32;
`ifdef MULT_SIGNED_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif
  localparam int BUDGET = LAT + 20;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           sgn;
  logic           busy;
  logic           done;
  logic [W-1:0]   prod_lo;
  logic [W-1:0]   prod_hi;

  logic [2*W-1:0] exp_q[$];
  int             n_run;
  int             n_fail;

  mult_seq #(
    .WIDTH(W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
`ifdef MULT_SIGNED_EN
    .sgn    (sgn),
`endif
    .busy   (busy),
    .done   (done),
    .prod_lo(prod_lo),
    .prod_hi(prod_hi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
    longint sx;
    longint sy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  task automatic drive_ops(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    a   = x;
    b   = y;
    sgn = s;
  endtask

  // Pulses start for one edge, queues the expected product, then scrambles the operands.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                        input logic [2*W-1:0] e);
    @(negedge clk);
    drive_ops(x, y, s);
    start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    n_run++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_on_start: busy=%b expected 1", busy);
    end
    @(negedge clk);
    start = 1'b0;
    drive_ops($urandom, $urandom, s);
  endtask

  task automatic wait_done(input string tag, input int exp_lat, output logic [2*W-1:0] e);
    int k = 0;
    e = '0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (done !== 1'b1 && k < BUDGET);
    n_run++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: no done within %0d cycles", tag, BUDGET);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      return;
    end
    if (k != exp_lat) begin
      n_fail++;
      $display("FAIL %s_latency: done after %0d edges, expected %0d", tag, k, exp_lat);
    end
    n_run++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_scoreboard: done with no expected product queued", tag);
      return;
    end
    e = exp_q.pop_front();
    n_run++;
    if (prod_hi !== e[2*W-1:W]) begin
      n_fail++;
      $display("FAIL %s_hi: prod_hi=%h expected %h", tag, prod_hi, e[2*W-1:W]);
    end
    n_run++;
    if (prod_lo !== e[W-1:0]) begin
      n_fail++;
      $display("FAIL %s_lo: prod_lo=%h expected %h", tag, prod_lo, e[W-1:0]);
    end
  endtask

  task automatic post_done(input string tag, input logic [2*W-1:0] e);
    @(posedge clk);
    #1;
    n_run++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_pulse: done=%b one cycle later, expected 0", tag, done);
    end
    n_run++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: busy=%b after done, expected 0", tag, busy);
    end
    n_run++;
    if ({prod_hi, prod_lo} !== e) begin
      n_fail++;
      $display("FAIL %s_hold: product=%h expected %h", tag, {prod_hi, prod_lo}, e);
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    n_run++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: busy=%b expected 0", busy); end
    n_run++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: done=%b expected 0", done); end
    n_run++;
    if (prod_lo !== '0) begin n_fail++; $display("FAIL rst_lo: prod_lo=%h expected 0", prod_lo); end
    n_run++;
    if (prod_hi !== '0) begin n_fail++; $display("FAIL rst_hi: prod_hi=%h expected 0", prod_hi); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_run++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_release: busy=%b expected 0", busy); end
  endtask

  task automatic test_unsigned();
    logic [2*W-1:0] e;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    launch(32'h0000_0003, 32'h0000_0005, 1'b0, 64'h0000_0000_0000_000F);
    wait_done("u_3x5", LAT, e);
    post_done("u_3x5", e);
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    wait_done("u_max", LAT, e);
    post_done("u_max", e);
    launch(32'h0000_0000, 32'h1234_5678, 1'b0, 64'h0);
    wait_done("u_zero", LAT, e);
    launch(32'h8000_0000, 32'h0000_0002, 1'b0, 64'h0000_0001_0000_0000);
    wait_done("u_carry", LAT, e);
    for (int i = 0; i < 4; i++) begin
      x = $urandom;
      y = $urandom;
      launch(x, y, 1'b0, model(x, y, 1'b0));
      wait_done("u_rand", LAT, e);
    end
  endtask

`ifdef MULT_SIGNED_EN
  task automatic test_signed();
    logic [2*W-1:0] e;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    launch(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
    wait_done("s_m3x5", LAT, e);
    post_done("s_m3x5", e);
    launch(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    wait_done("s_minsq", LAT, e);
    launch(32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, 64'h0000_0000_0000_000F);
    wait_done("s_m3xm5", LAT, e);
    launch(32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000);
    wait_done("s_minx1", LAT, e);
    launch(32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 64'h0000_0004_FFFF_FFF1);
    wait_done("s_off", LAT, e);
    for (int i = 0; i < 3; i++) begin
      x = $urandom;
      y = $urandom;
      launch(x, y, 1'b1, model(x, y, 1'b1));
      wait_done("s_rand", LAT, e);
    end
  endtask
`endif

  task automatic test_ignore_start();
    logic [2*W-1:0] e;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    int             n_done = 0;
    int             k_done = 0;
    x = $urandom;
    y = $urandom;
    e = model(x, y, 1'b0);
    launch(x, y, 1'b0, e);
    for (int k = 1; k <= LAT + 4; k++) begin
      start = (k == 5 || k == 20);
      if (start) drive_ops($urandom, $urandom, 1'b1);
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        n_done++;
        k_done = k;
        n_run++;
        if ({prod_hi, prod_lo} !== e) begin
          n_fail++;
          $display("FAIL ign_value: product=%h expected %h", {prod_hi, prod_lo}, e);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    exp_q.delete();
    n_run++;
    if (n_done != 1) begin
      n_fail++;
      $display("FAIL ign_count: %0d done pulses, expected 1", n_done);
    end
    n_run++;
    if (k_done != LAT) begin
      n_fail++;
      $display("FAIL ign_latency: done after %0d edges, expected %0d", k_done, LAT);
    end
  endtask

  task automatic test_reset_mid();
    logic [2*W-1:0] e;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    int             n_done = 0;
    x = $urandom | 32'h8000_0001;
    y = $urandom | 32'h0000_0001;
    launch(x, y, 1'b0, model(x, y, 1'b0));
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_run++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: busy=%b expected 0", busy); end
    n_run++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: done=%b expected 0", done); end
    n_run++;
    if (prod_lo !== '0) begin n_fail++; $display("FAIL midrst_lo: prod_lo=%h expected 0", prod_lo); end
    n_run++;
    if (prod_hi !== '0) begin n_fail++; $display("FAIL midrst_hi: prod_hi=%h expected 0", prod_hi); end
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 4) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) n_done++;
    end
    n_run++;
    if (n_done != 0) begin
      n_fail++;
      $display("FAIL midrst_nodone: %0d done pulses after reset, expected 0", n_done);
    end
    n_run++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: busy=%b expected 0", busy); end
    x = $urandom;
    y = $urandom;
    launch(x, y, 1'b0, model(x, y, 1'b0));
    wait_done("midrst_after", LAT, e);
    post_done("midrst_after", e);
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] e;
    logic [W-1:0]   xs[3];
    logic [W-1:0]   ys[3];
    int             n_done = 0;
    for (int i = 0; i < 3; i++) begin
      xs[i] = $urandom;
      ys[i] = $urandom;
    end
    @(negedge clk);
    drive_ops(xs[0], ys[0], 1'b0);
    start = 1'b1;
    exp_q.push_back(model(xs[0], ys[0], 1'b0));
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      wait_done("b2b", (i == 0) ? LAT : LAT + 1, e);
      if (i < 2) begin
        drive_ops(xs[i+1], ys[i+1], 1'b0);
        exp_q.push_back(model(xs[i+1], ys[i+1], 1'b0));
      end else begin
        start = 1'b0;
      end
    end
    repeat (LAT + 4) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) n_done++;
    end
    n_run++;
    if (n_done != 0) begin
      n_fail++;
      $display("FAIL b2b_extra: %0d extra done pulses, expected 0", n_done);
    end
    n_run++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: busy=%b expected 0", busy); end
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    sgn    = 1'b0;
    test_reset();
    test_unsigned();
`ifdef MULT_SIGNED_EN
    test_signed();
`endif
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
